mem_bus_responder: RTL and testbench

Memory-side responder for the core's `imem_*` / `dmem_*` request bus: a word-addressed SRAM model that accepts chip-enable requests, inserts programmable (optionally pseudo-random) wait states via `stall`, performs strobed writes and returns read data or a bus error. One instance per port serves simulation benches and formal/FPGA harnesses. It replaces free-running random `rdata`/`stall` stimulus with a memory whose responses are coherent and checkable.

---
 rtl/mem_bus_responder.sv | 132 +++++++++++++
 tb/tb_mem_bus_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Word-addressed SRAM responder for the core request bus: strobed writes, error on bad address.
// Latency WAIT_CYCLES (+0..3 LFSR cycles) stall cycles per request; requester holds inputs while mem_stall is high.
module mem_bus_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_cen,
  input  logic                     mem_wen,
  input  logic [3:0]               mem_strb,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic [31:0]              mem_rdata,
  output logic                     mem_error,
  output logic                     mem_stall,
  input  logic                     bd_wen,
  input  logic [$clog2(DEPTH)-1:0] bd_addr,
  input  logic [31:0]              bd_wdata
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = $clog2(WAIT_CYCLES + 4);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_dec;
  logic [CW-1:0]  load_val;
  logic [15:0]    lfsr;
  logic [15:0]    lfsr_nxt;

  logic [31:0]    offset;
  logic           addr_err;
  logic [AW-1:0]  word_idx;
  logic [31:0]    rsp_rdata;
  logic [31:0]    wr_word;
  logic           bus_commit;

  logic [31:0]    mem [DEPTH];

  // Offset arithmetic wraps addresses below BASE to large values, so one compare covers both bounds.
  assign offset    = mem_addr - BASE;
  assign addr_err  = ({1'b0, offset} >= SPAN) || (offset[1:0] != 2'b00);
  assign word_idx  = offset[AW+1:2];
  assign rsp_rdata = addr_err ? 32'h0 : mem[word_idx];

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cnt_dec   = cnt - CW'(1);
  assign mem_stall = mem_cen && (state != DONE);

  always_comb begin
    load_val = CW'(WAIT_CYCLES - 1);
    if (RAND_STALL) begin
      load_val = load_val + CW'(lfsr[1:0]);
    end
  end

  always_comb begin
    wr_word = mem[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (mem_strb[i]) begin
        wr_word[8*i +: 8] = mem_wdata[8*i +: 8];
      end
    end
  end

  assign bus_commit = (state == DONE) && mem_cen && mem_wen && !mem_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      mem_rdata <= 32'h0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_cen) begin
            cnt  <= load_val;
            lfsr <= lfsr_nxt;
            if (load_val != '0) begin
              state <= WAIT;
            end else begin
              state     <= DONE;
              mem_rdata <= rsp_rdata;
              mem_error <= addr_err;
            end
          end
        end
        WAIT: begin
          // A requester that lets go mid-wait has abandoned the access.
          if (!mem_cen) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_dec;
            if (cnt_dec == '0) begin
              state     <= DONE;
              mem_rdata <= rsp_rdata;
              mem_error <= addr_err;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backdoor write is issued last so it overrides a bus write to the same word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (bus_commit) begin
        mem[word_idx] <= wr_word;
      end
      if (bd_wen) begin
        mem[bd_addr] <= bd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a fixed-latency instance and a random-stall instance share clock/reset.
module tb_mem_bus_responder;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
    int          n;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cen   [2];
  logic        wen   [2];
  logic [3:0]  strb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        stall [2];
  logic        bdw   [2];
  logic [9:0]  bda   [2];
  logic [31:0] bdd   [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] ref_lfsr;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mem_bus_responder u_dut0 (
    .clock(clock), .reset(reset),
    .mem_cen(cen[0]), .mem_wen(wen[0]), .mem_strb(strb[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_error(err[0]), .mem_stall(stall[0]),
    .bd_wen(bdw[0]), .bd_addr(bda[0]), .bd_wdata(bdd[0])
  );

  mem_bus_responder #(.WAIT_CYCLES(3), .RAND_STALL(1'b1)) u_dut1 (
    .clock(clock), .reset(reset),
    .mem_cen(cen[1]), .mem_wen(wen[1]), .mem_strb(strb[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_error(err[1]), .mem_stall(stall[1]),
    .bd_wen(bdw[1]), .bd_addr(bda[1]), .bd_wdata(bdd[1])
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles of each request and scores every completion.
  initial begin
    int   scnt [2];
    exp_t e;
    scnt[0] = 0;
    scnt[1] = 0;
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (reset || !cen[d]) begin
          scnt[d] = 0;
        end else if (stall[d]) begin
          scnt[d]++;
        end else begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion dut%0d: got a response, expected none pending", d);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d_error", d), 32'(err[d]), 32'(e.err));
            if (e.chk_rd) chk($sformatf("dut%0d_rdata", d), rdata[d], e.rd);
            chk($sformatf("dut%0d_stall_cycles", d), 32'(scnt[d]), 32'(e.n));
          end
          scnt[d] = 0;
        end
      end
    end
  end

  task automatic start_req(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                           input bit chk_rd, input bit push);
    exp_t e;
    e.err    = e_err;
    e.rd     = e_rd;
    e.chk_rd = chk_rd;
    if (d == 0) begin
      e.n = 1;
    end else begin
      e.n      = 3 + int'(ref_lfsr[1:0]);
      ref_lfsr = lfsr_step(ref_lfsr);
    end
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    cen[d]   = 1'b1;
    wen[d]   = w;
    strb[d]  = s;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  task automatic wait_done(input int d);
    int k;
    k = 0;
    forever begin
      @(negedge clock);
      if (!stall[d]) break;
      k++;
      if (k > 40) begin
        checks++;
        errors++;
        $display("FAIL timeout dut%0d: stall still high after %0d cycles, expected completion", d, k);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic req(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input bit chk_rd);
    start_req(d, w, s, a, wd, e_err, e_rd, chk_rd, 1'b1);
    wait_done(d);
  endtask

  task automatic idle(input int d);
    cen[d] = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic bd(input int d, input logic [9:0] idx, input logic [31:0] data);
    bdw[d] = 1'b1;
    bda[d] = idx;
    bdd[d] = data;
    @(posedge clock);
    #1;
    bdw[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cen[d] = 1'b0; wen[d] = 1'b0; strb[d] = 4'h0; addr[d] = 32'h0;
      wdata[d] = 32'h0; bdw[d] = 1'b0; bda[d] = 10'h0; bdd[d] = 32'h0;
    end
    ref_lfsr = 16'hACE1;
    cen[0]   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_stall_follows_cen", 32'(stall[0]), 32'h1);
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_error", 32'(err[0]), 32'h0);
    cen[0] = 1'b0;
    reset  = 1'b0;
    @(posedge clock);
    #1;

    bd(0, 10'd0, 32'h0BAD_F00D);
    bd(0, 10'd2, 32'h0202_0202);
    bd(0, 10'd3, 32'hDEAD_BEEF);
    bd(0, 10'd4, 32'hFFFF_FFFF);
    bd(0, 10'd5, 32'h0000_0000);
    bd(0, 10'd1023, 32'h600D_CAFE);
    for (int i = 0; i < 16; i++) bd(1, 10'(i), {16'hC0DE, 16'(i)});

    // Fixed single-cycle latency instance, back-to-back requests.
    req(0, 1'b0, 4'h0, 32'h0000_000C, 32'h0,          1'b0, 32'hDEAD_BEEF, 1'b1);
    req(0, 1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0,       1'b0);
    req(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,          1'b0, 32'hFF22_FF44, 1'b1);
    req(0, 1'b1, 4'h0, 32'h0000_000C, 32'h0,          1'b0, 32'h0,         1'b0);
    req(0, 1'b0, 4'h0, 32'h0000_000C, 32'h0,          1'b0, 32'hDEAD_BEEF, 1'b1);
    req(0, 1'b0, 4'h0, 32'h0000_0FFC, 32'h0,          1'b0, 32'h600D_CAFE, 1'b1);
    chk("rdata_holds_after_done", rdata[0], 32'h600D_CAFE);
    req(0, 1'b0, 4'h0, 32'h0000_0002, 32'h0,          1'b1, 32'h0,         1'b1);
    chk("error_clears_after_done", 32'(err[0]), 32'h0);
    req(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0,          1'b1, 32'h0,         1'b1);
    req(0, 1'b1, 4'hF, 32'h0000_0002, 32'h0,          1'b1, 32'h0,         1'b1);
    req(0, 1'b1, 4'hF, 32'h0000_1000, 32'h0,          1'b1, 32'h0,         1'b1);
    req(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,          1'b0, 32'h0BAD_F00D, 1'b1);

    // Backdoor lands on the same edge a bus write to word 5 commits.
    start_req(0, 1'b1, 4'hF, 32'h0000_0014, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    bdw[0] = 1'b1;
    bda[0] = 10'd5;
    bdd[0] = 32'h5555_5555;
    wait_done(0);
    bdw[0] = 1'b0;
    req(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0, 1'b0, 32'h5555_5555, 1'b1);
    idle(0);

    // Random-stall instance: 50 back-to-back reads.
    for (int i = 0; i < 50; i++) begin
      req(1, 1'b0, 4'h0, 32'((i % 16) * 4), 32'h0, 1'b0, {16'hC0DE, 16'(i % 16)}, 1'b1);
    end
    idle(1);

    // Requester drops cen while the write is still waiting.
    start_req(1, 1'b1, 4'hF, 32'h0000_0024, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    cen[1] = 1'b0;
    @(posedge clock);
    #1;
    chk("drop_error", 32'(err[1]), 32'h0);
    req(1, 1'b0, 4'h0, 32'h0000_0024, 32'h0, 1'b0, 32'hC0DE_0009, 1'b1);

    // Reset during a waiting write; backdoor on the other instance is ignored while reset is high.
    start_req(1, 1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    bdw[0] = 1'b1;
    bda[0] = 10'd2;
    bdd[0] = 32'h2222_2222;
    @(posedge clock);
    #1;
    chk("mid_reset_stall", 32'(stall[1]), 32'h1);
    chk("mid_reset_rdata", rdata[1], 32'h0);
    chk("mid_reset_error", 32'(err[1]), 32'h0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    cen[1]   = 1'b0;
    bdw[0]   = 1'b0;
    ref_lfsr = 16'hACE1;
    @(posedge clock);
    #1;
    req(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0, 32'hC0DE_0008, 1'b1);
    idle(1);
    req(0, 1'b0, 4'h0, 32'h0000_0008, 32'h0, 1'b0, 32'h0202_0202, 1'b1);
    idle(0);

    repeat (3) @(posedge clock);
    #1;
    chk("dut0_pending_left", 32'(q0.size()), 32'h0);
    chk("dut1_pending_left", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
